// File: rtl/hdmi_island_framer.sv
// hdmi_island_framer
// Last HDMI stage before the 10:1 serialisers. Inputs run through a
// D = PRE_LEN+GB_LEN delay line. A look-ahead FSM watches the raw i_de and
// i_data rises, so preambles and guard bands can be placed in the D cycles
// ahead of the delayed video / island data. Each channel emits 2b/10b
// control, TERC4 or DVI 8b/10b symbols.
// Build option: define HDMI_DATA_ISLAND_EN for HDMI data islands.
// Without it the block is a plain DVI encoder with the same 11-cycle latency.
module hdmi_island_framer #(
    parameter int PRE_LEN = 8,
    parameter int GB_LEN  = 2
) (
    input  logic       i_pixclk,
    input  logic       i_reset,
    input  logic       i_de,
    input  logic       i_hSync,
    input  logic       i_vSync,
    input  logic [7:0] i_r,
    input  logic [7:0] i_g,
    input  logic [7:0] i_b,
    input  logic [3:0] i_d0,
    input  logic [3:0] i_d1,
    input  logic [3:0] i_d2,
    input  logic       i_data,
    output logic [9:0] o_tmds0,
    output logic [9:0] o_tmds1,
    output logic [9:0] o_tmds2,
    output logic       o_err
);

    localparam int D = PRE_LEN + GB_LEN;

    localparam logic [9:0] CTL_00 = 10'b1101010100;

    typedef enum logic [2:0] {
        IDLE, PRE_VID, GB_VID, VIDEO, PRE_DAT, GB_DAT, ISLAND, TRAIL
    } state_t;

    // One delay-line slot. Island fields only exist when islands are built.
    typedef struct packed {
        logic       de;
        logic       hs;
        logic       vs;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
`ifdef HDMI_DATA_ISLAND_EN
        logic       data;
        logic [3:0] d0;
        logic [3:0] d1;
        logic [3:0] d2;
`endif
    } stage_t;

    typedef struct packed {
        logic [9:0]        sym;
        logic signed [5:0] disp;
    } tmds_t;

    // 2b/10b control symbol for {c1,c0}.
    function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
        case (c)
            2'b00:   ctrl_sym = 10'b1101010100;
            2'b01:   ctrl_sym = 10'b0010101011;
            2'b10:   ctrl_sym = 10'b0101010100;
            default: ctrl_sym = 10'b1010101011;
        endcase
    endfunction

    // DVI 1.0 8b/10b encoder: transition minimisation then DC balancing
    // against the channel's running disparity.
    function automatic tmds_t tmds_enc(input logic [7:0] d, input logic signed [5:0] disp);
        tmds_t             res;
        logic [8:0]        qm;
        logic [3:0]        n1d;
        logic [3:0]        n1q;
        logic signed [5:0] diff;
        n1d = 4'd0;
        for (int i = 0; i < 8; i++) n1d = n1d + {3'b000, d[i]};
        qm = 9'd0;
        qm[0] = d[0];
        if (n1d > 4'd4 || (n1d == 4'd4 && !d[0])) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
            qm[8] = 1'b1;
        end
        n1q = 4'd0;
        for (int i = 0; i < 8; i++) n1q = n1q + {3'b000, qm[i]};
        // ones minus zeros of qm[7:0]
        diff = $signed({1'b0, n1q, 1'b0}) - 6'sd8;
        if (disp == 6'sd0 || diff == 6'sd0) begin
            res.sym  = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            res.disp = qm[8] ? disp + diff : disp - diff;
        end else if ((disp > 6'sd0 && diff > 6'sd0) || (disp < 6'sd0 && diff < 6'sd0)) begin
            res.sym  = {1'b1, qm[8], ~qm[7:0]};
            res.disp = disp + (qm[8] ? 6'sd2 : 6'sd0) - diff;
        end else begin
            res.sym  = {1'b0, qm[8], qm[7:0]};
            res.disp = disp - (qm[8] ? 6'sd0 : 6'sd2) + diff;
        end
        return res;
    endfunction

`ifdef HDMI_DATA_ISLAND_EN
    localparam logic [3:0] PRE_LAST = 4'(PRE_LEN - 1);
    localparam logic [3:0] GB_LAST  = 4'(GB_LEN - 1);
    localparam logic [9:0] GB_A     = 10'b1011001100;
    localparam logic [9:0] GB_B     = 10'b0100110011;

    // HDMI 1.3 TERC4 table.
    function automatic logic [9:0] terc4(input logic [3:0] n);
        case (n)
            4'h0:    terc4 = 10'b1010011100;
            4'h1:    terc4 = 10'b1001100011;
            4'h2:    terc4 = 10'b1011100100;
            4'h3:    terc4 = 10'b1011100010;
            4'h4:    terc4 = 10'b0101110001;
            4'h5:    terc4 = 10'b0100011110;
            4'h6:    terc4 = 10'b0110001110;
            4'h7:    terc4 = 10'b0100111100;
            4'h8:    terc4 = 10'b1011001100;
            4'h9:    terc4 = 10'b0100111001;
            4'hA:    terc4 = 10'b0110011100;
            4'hB:    terc4 = 10'b1011000110;
            4'hC:    terc4 = 10'b1010001110;
            4'hD:    terc4 = 10'b1001110001;
            4'hE:    terc4 = 10'b0101100011;
            default: terc4 = 10'b1011000011;
        endcase
    endfunction
`endif

    stage_t              stg_in;
    stage_t [D-1:0]      dly_q;
    stage_t              q;        // the *_q view: inputs delayed by D
    state_t              state_d;
    logic [2:0][9:0]     vid_sym;
    logic [2:0][9:0]     sym_d;
    logic [2:0][9:0]     sym_q;
    logic [2:0][7:0]     pix;

    // Pack the raw inputs into one delay-line slot.
    always_comb begin
        stg_in    = '0;
        stg_in.de = i_de;
        stg_in.hs = i_hSync;
        stg_in.vs = i_vSync;
        stg_in.r  = i_r;
        stg_in.g  = i_g;
        stg_in.b  = i_b;
`ifdef HDMI_DATA_ISLAND_EN
        stg_in.data = i_data;
        stg_in.d0   = i_d0;
        stg_in.d1   = i_d1;
        stg_in.d2   = i_d2;
`endif
    end

    // D-stage delay line; slot 0 also serves as the previous-cycle copy for edge detection.
    always_ff @(posedge i_pixclk or posedge i_reset) begin
        if (i_reset) dly_q <= '0;
        else         dly_q <= {dly_q[D-2:0], stg_in};
    end

    assign q   = dly_q[D-1];
    assign pix = {q.r, q.g, q.b};  // ch2 red, ch1 green, ch0 blue

    // Per-channel 8b/10b with its own running disparity, zeroed outside video.
    for (genvar c = 0; c < 3; c++) begin : g_ch
        logic signed [5:0] disp_q;
        tmds_t             enc;
        always_comb enc = tmds_enc(pix[c], disp_q);
        assign vid_sym[c] = enc.sym;
        // Disparity follows the symbol actually sent next cycle.
        always_ff @(posedge i_pixclk or posedge i_reset) begin
            if (i_reset) disp_q <= 6'sd0;
            else         disp_q <= (state_d == VIDEO) ? enc.disp : 6'sd0;
        end
    end

`ifdef HDMI_DATA_ISLAND_EN
    state_t     state_q;
    logic [3:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic       de_rise, data_rise;

    assign de_rise   = i_de & ~dly_q[0].de;
    assign data_rise = i_data & ~dly_q[0].data;

    // State, period counter and sticky conflict flag.
    always_ff @(posedge i_pixclk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next state: raw rises open a period D cycles early; video always wins.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 4'd1;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (de_rise) begin
                    state_d = PRE_VID;
                    cnt_d   = 4'd0;
                    if (data_rise) err_d = 1'b1;
                end else if (data_rise) begin
                    state_d = PRE_DAT;
                    cnt_d   = 4'd0;
                end
            end
            PRE_VID, GB_VID, VIDEO: begin
                if (data_rise) err_d = 1'b1;
                if (state_q == PRE_VID && cnt_q == PRE_LAST) begin
                    state_d = GB_VID;
                    cnt_d   = 4'd0;
                end else if (state_q == GB_VID && cnt_q == GB_LAST) begin
                    state_d = VIDEO;
                end else if (state_q == VIDEO && !q.de) begin
                    state_d = IDLE;
                end
            end
            PRE_DAT, GB_DAT, ISLAND, TRAIL: begin
                if (de_rise) begin
                    state_d = PRE_VID;
                    cnt_d   = 4'd0;
                    err_d   = 1'b1;
                end else begin
                    if (state_q == TRAIL && data_rise) err_d = 1'b1;
                    if (state_q == PRE_DAT && cnt_q == PRE_LAST) begin
                        state_d = GB_DAT;
                        cnt_d   = 4'd0;
                    end else if (state_q == GB_DAT && cnt_q == GB_LAST) begin
                        state_d = ISLAND;
                    end else if (state_q == ISLAND && !q.data) begin
                        state_d = TRAIL;
                        cnt_d   = 4'd0;
                    end else if (state_q == TRAIL && cnt_q == GB_LAST) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_err = err_q;
`else
    logic dvi_unused;
    assign dvi_unused = ^{i_data, i_d0, i_d1, i_d2};

    // DVI: the delayed DE alone selects video or control.
    always_comb state_d = q.de ? VIDEO : IDLE;

    assign o_err = 1'b0;
`endif

    // Output symbols for the state about to be entered.
    always_comb begin
        sym_d[0] = ctrl_sym({q.vs, q.hs});
        sym_d[1] = CTL_00;
        sym_d[2] = CTL_00;
        case (state_d)
            VIDEO: sym_d = vid_sym;
`ifdef HDMI_DATA_ISLAND_EN
            PRE_VID: sym_d[1] = ctrl_sym(2'b01);
            PRE_DAT: begin
                sym_d[1] = ctrl_sym(2'b01);
                sym_d[2] = ctrl_sym(2'b01);
            end
            GB_VID: sym_d = {GB_A, GB_B, GB_A};
            GB_DAT, TRAIL: begin
                sym_d[0] = terc4({2'b11, q.vs, q.hs});
                sym_d[1] = GB_B;
                sym_d[2] = GB_B;
            end
            ISLAND: sym_d = {terc4(q.d2), terc4(q.d1), terc4(q.d0)};
`endif
            default: ;
        endcase
    end

    // Registered symbols straight to the serialisers.
    always_ff @(posedge i_pixclk or posedge i_reset) begin
        if (i_reset) sym_q <= {CTL_00, CTL_00, CTL_00};
        else         sym_q <= sym_d;
    end

    assign o_tmds0 = sym_q[0];
    assign o_tmds1 = sym_q[1];
    assign o_tmds2 = sym_q[2];

endmodule

// File: tb/tb_hdmi_island_framer.sv
// Directed bench for hdmi_island_framer; expectations follow the build
// selected by HDMI_DATA_ISLAND_EN.
module tb_hdmi_island_framer;

    localparam logic [9:0] C00  = 10'b1101010100;
    localparam logic [9:0] C01  = 10'b0010101011;
    localparam logic [9:0] C10  = 10'b0101010100;
    localparam logic [9:0] C11  = 10'b1010101011;
    localparam logic [9:0] GB_A = 10'b1011001100;
    localparam logic [9:0] GB_B = 10'b0100110011;
    localparam logic [9:0] T0   = 10'b1010011100;
    localparam logic [9:0] TF   = 10'b1011000011;
    localparam logic [9:0] Z    = 10'b0100000000;
`ifdef HDMI_DATA_ISLAND_EN
    localparam bit ISL = 1'b1;
`else
    localparam bit ISL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       de, hs, vs, data;
    logic [7:0] r, g, b;
    logic [3:0] d0, d1, d2;
    logic [9:0] t0, t1, t2;
    logic       err;
    int         checks   = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    hdmi_island_framer #(.PRE_LEN(8), .GB_LEN(2)) dut (
        .i_pixclk(clk), .i_reset(rst), .i_de(de), .i_hSync(hs), .i_vSync(vs),
        .i_r(r), .i_g(g), .i_b(b), .i_d0(d0), .i_d1(d1), .i_d2(d2), .i_data(data),
        .o_tmds0(t0), .o_tmds1(t1), .o_tmds2(t2), .o_err(err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic a_de, input logic a_hs, input logic a_vs,
                          input logic [7:0] a_r, input logic [7:0] a_g, input logic [7:0] a_b,
                          input logic a_data, input logic [3:0] a_d0);
        de = a_de; hs = a_hs; vs = a_vs; r = a_r; g = a_g; b = a_b;
        data = a_data; d0 = a_d0; d1 = 4'h0; d2 = 4'h0;
    endtask

    task automatic idle(input logic a_hs, input logic a_vs, input int n);
        set_in(1'b0, a_hs, a_vs, 8'h00, 8'h00, 8'h00, 1'b0, 4'h0);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 4'h0);
        step();
        step();
        checks++;
        if ({t2, t1, t0, err} !== {C00, C00, C00, 1'b0}) begin
            failures++;
            $display("FAIL reset_state got=%b %b %b err=%b exp=%b %b %b err=0", t2, t1, t0, err, C00, C00, C00);
        end
        rst = 1'b0;
        idle(1'b0, 1'b0, 12);
        checks++;
        if ({t2, t1, t0} !== {C00, C00, C00}) begin
            failures++;
            $display("FAIL after_reset_idle got=%b %b %b", t2, t1, t0);
        end
    endtask

    task automatic test_blank_sync();
        logic [1:0] sv [3];
        logic [9:0] ex [3];
        sv[0] = 2'b01; ex[0] = C01;   // {vs,hs}
        sv[1] = 2'b10; ex[1] = C10;
        sv[2] = 2'b11; ex[2] = C11;
        for (int k = 0; k < 3; k++) begin
            idle(sv[k][0], sv[k][1], 11);
            checks++;
            if ({t2, t1, t0} !== {C00, C00, ex[k]}) begin
                failures++;
                $display("FAIL blank_sync vs_hs=%b got=%b %b %b exp ch0=%b ch1/2=%b", sv[k], t2, t1, t0, ex[k], C00);
            end
        end
        idle(1'b0, 1'b0, 12);
    endtask

    task automatic test_video();
        logic [23:0] px [3];
        logic [29:0] vx [3];
        logic [29:0] e;
        px[0] = {8'h00, 8'h00, 8'h00}; vx[0] = {Z, Z, Z};
        px[1] = {8'hFF, 8'h10, 8'h00}; vx[1] = {10'b0011111111, 10'b0111110000, 10'b1111111111};
        px[2] = {8'h80, 8'hA5, 8'hFF}; vx[2] = {10'b1101111111, 10'b0101100011, 10'b1000000000};
        for (int j = 0; j <= 16; j++) begin
            if (j < 3) set_in(1'b1, 1'b0, 1'b0, px[j][23:16], px[j][15:8], px[j][7:0], 1'b0, 4'h0);
            else       set_in(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 4'h0);
            if (j >= 11 && j <= 13)            e = vx[j-11];
            else if (ISL && j >= 1 && j <= 8)  e = {C00, C01, C00};
            else if (ISL && j >= 9 && j <= 10) e = {GB_A, GB_B, GB_A};
            else                               e = {C00, C00, C00};
            checks++;
            if ({t2, t1, t0} !== e) begin
                failures++;
                $display("FAIL video j=%0d got=%b exp=%b", j, {t2, t1, t0}, e);
            end
            step();
        end
        idle(1'b0, 1'b0, 4);
    endtask

    task automatic test_back_to_back();
        logic [29:0] e;
        int          k;
        for (int j = 0; j <= 33; j++) begin
            set_in((j == 0 || j == 20), 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 4'h0);
            k = (j >= 20) ? j - 20 : j;
            if (k == 11)                       e = {Z, Z, Z};
            else if (ISL && k >= 1 && k <= 8)  e = {C00, C01, C00};
            else if (ISL && k >= 9 && k <= 10) e = {GB_A, GB_B, GB_A};
            else                               e = {C00, C00, C00};
            checks++;
            if ({t2, t1, t0} !== e) begin
                failures++;
                $display("FAIL back_to_back j=%0d got=%b exp=%b", j, {t2, t1, t0}, e);
            end
            step();
        end
    endtask

    task automatic test_island();
        logic [29:0] e;
        idle(1'b1, 1'b1, 12);
        for (int j = 0; j <= 80; j++) begin
            set_in(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, (j < 64), 4'hF);
            if (ISL && j >= 1 && j <= 8)        e = {C01, C01, C11};
            else if (ISL && j >= 9 && j <= 10)  e = {GB_B, GB_B, TF};
            else if (ISL && j >= 11 && j <= 74) e = {T0, T0, TF};
            else if (ISL && j >= 75 && j <= 76) e = {GB_B, GB_B, TF};
            else                                e = {C00, C00, C11};
            checks++;
            if ({t2, t1, t0} !== e) begin
                failures++;
                $display("FAIL island j=%0d got=%b exp=%b", j, {t2, t1, t0}, e);
            end
            step();
        end
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL island_err got=%b exp=0", err);
        end
        idle(1'b0, 1'b0, 12);
    endtask

    task automatic test_conflict();
        logic [29:0] e;
        logic        ee;
        for (int j = 0; j <= 24; j++) begin
            set_in((j == 5), 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, (j < 20), 4'h0);
            if (j == 16)                        e = {Z, Z, Z};
            else if (ISL && j >= 1 && j <= 5)   e = {C01, C01, C00};
            else if (ISL && j >= 6 && j <= 13)  e = {C00, C01, C00};
            else if (ISL && j >= 14 && j <= 15) e = {GB_A, GB_B, GB_A};
            else                                e = {C00, C00, C00};
            ee = ISL && (j >= 6);
            checks++;
            if ({t2, t1, t0, err} !== {e, ee}) begin
                failures++;
                $display("FAIL conflict j=%0d got=%b err=%b exp=%b err=%b", j, {t2, t1, t0}, err, e, ee);
            end
            step();
        end
    endtask

    task automatic test_reset_mid_video();
        logic [9:0] e0;
        idle(1'b0, 1'b0, 12);
        checks++;
        if (err !== ISL) begin
            failures++;
            $display("FAIL err_sticky got=%b exp=%b", err, ISL);
        end
        for (int j = 0; j < 14; j++) begin
            set_in(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 4'h0);
            step();
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({t2, t1, t0, err} !== {C00, C00, C00, 1'b0}) begin
            failures++;
            $display("FAIL reset_mid_video got=%b %b %b err=%b exp=%b x3 err=0", t2, t1, t0, err, C00);
        end
        set_in(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 4'h0);
        step();
        step();
        rst = 1'b0;
        for (int j = 0; j <= 12; j++) begin
            e0 = (j >= 11) ? C01 : C00;
            checks++;
            if ({t2, t1, t0, err} !== {C00, C00, e0, 1'b0}) begin
                failures++;
                $display("FAIL resume_after_reset j=%0d got=%b %b %b err=%b exp ch0=%b", j, t2, t1, t0, err, e0);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_blank_sync();
        test_video();
        test_back_to_back();
        test_island();
        test_conflict();
        test_reset_mid_video();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
